// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// Performs a WIDTH-bit add or subtract on one shared external 4-bit
// ripple-carry adder. One nibble is processed per clock, least significant
// nibble first. The inter-nibble carry is kept in a register. Subtraction
// is done as a + ~b + 1: b is inverted when the operands are captured, and
// the carry register starts at 1.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic [3:0]       rca_a,
    output logic [3:0]       rca_b,
    output logic             rca_cin,
    input  logic [3:0]       rca_s,
    input  logic             rca_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [IW-1:0]    idx_r;
    logic             ovf_s;

    // Signed overflow of the top nibble. The carry into the MSB is
    // recovered as a3 ^ b3 ^ s3. Overflow is that carry XOR the carry out.
    function automatic logic msb_overflow(input logic a3, input logic b3,
                                          input logic s3, input logic co);
        msb_overflow = (a3 ^ b3 ^ s3) ^ co;
    endfunction

    // Present the current nibble to the shared adder only while running.
    always_comb begin
        rca_a   = 4'h0;
        rca_b   = 4'h0;
        rca_cin = 1'b0;
        if (state_r == ST_RUN) begin
            rca_a   = a_r[{idx_r, 2'b00} +: 4];
            rca_b   = b_r[{idx_r, 2'b00} +: 4];
            rca_cin = carry_r;
        end else begin
            rca_a   = 4'h0;
            rca_b   = 4'h0;
            rca_cin = 1'b0;
        end
    end

    // Overflow candidate computed from the adder's view of the current nibble.
    always_comb begin
        ovf_s = msb_overflow(rca_a[3], rca_b[3], rca_s[3], rca_cout);
    end

    // Sequencer: capture operands, step through the nibbles, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub;
                        idx_r   <= '0;
                        sum     <= '0;
                        c_out   <= 1'b0;
                        ovf     <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum[{idx_r, 2'b00} +: 4] <= rca_s;
                    carry_r <= rca_cout;
                    idx_r   <= idx_r + IW'(1);
                    if (idx_r == LAST_IDX) begin
                        c_out   <= rca_cout;
                        ovf     <= ovf_s;
                        done    <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        done    <= 1'b0;
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    idx_r   <= '0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    idx_r   <= '0;
                    carry_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external 4-bit ripple-carry adder (RCA_4_bit), one nibble per clock, LSB nibble first. Sits between a requesting datapath (start/done handshake) and the shared RCA instance, driving its a/b/c_in and capturing s/c_out. Carry is held in a register between nibbles; subtraction is done by operand inversion with carry-in 1.

## Interface
- WIDTH, 16, operand width in bits; multiple of 4, at least 4; NIB = WIDTH/4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result; held until next accepted start
- c_out  output  1  final carry (sub: 1 = no borrow)
- ovf  output  1  signed overflow
- rca_a  output  4  nibble to adder A
- rca_b  output  4  nibble to adder B (already inverted when sub)
- rca_cin  output  1  carry to adder
- rca_s  input  4  adder sum
- rca_cout  input  1  adder carry out

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: on edge with start=1: a_reg←a, b_reg←(sub ? ~b : b), carry←sub, idx←0, sum←0, c_out←0, ovf←0, → RUN. start=0: stay.
- RUN: combinationally rca_a = a_reg[4*idx+:4], rca_b = b_reg[4*idx+:4], rca_cin = carry. Each edge: sum[4*idx+:4]←rca_s, carry←rca_cout, idx←idx+1.
- On edge where idx = NIB−1: also c_out←rca_cout, ovf←(rca_a[3]^rca_b[3]^rca_s[3]) ^ rca_cout (carry into MSB xor carry out), → DONE.
- DONE: done=1 for exactly one cycle; → IDLE unconditionally. start during DONE ignored.
- start during RUN/DONE ignored; operands/sub changes after acceptance have no effect.
- Outside RUN: rca_a=0, rca_b=0, rca_cin=0.
- Width rule: sum is result mod 2^WIDTH; no saturation.

## Timing
- Reset values (async, immediate): state IDLE, busy 0, done 0, sum 0, c_out 0, ovf 0, idx 0, carry 0, rca_* 0.
- start sampled at edge E0 → busy high from E0; RUN occupies cycles E0..E(NIB); done high in cycle after E(NIB); sum/c_out/ovf valid from same edge and stable thereafter.
- Latency start-edge → done = NIB+1 cycles (5 for WIDTH=16); throughput one op per NIB+2 cycles (start accepted in IDLE cycle following DONE).
- Adder path is combinational within one cycle: rca_s/rca_cout must settle from rca_a/rca_b/rca_cin in the same cycle.
- rst_n low mid-RUN: abort, all outputs to reset values asynchronously, no done pulse; after release, IDLE awaiting start.
- WIDTH=4: single RUN cycle, latency 2.

## Test plan
- WIDTH=16, sub=0, a=0x1234, b=0x4321 → done after 5 cycles, sum=0x5555, c_out=0, ovf=0; rca_cin per nibble 0,0,0,0.
- sub=0, a=0xFFFF, b=0x0001 → sum=0x0000, c_out=1, ovf=0; carry ripples through all 4 nibble cycles (rca_cin 0,1,1,1).
- sub=0, a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, ovf=1; then sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, c_out=1, ovf=1.
- sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, c_out=0 (borrow), ovf=0; rca_b first nibble = 0x8, rca_cin first = 1.
- start pulsed again 2 cycles into RUN with a=0xAAAA → ignored; first result unchanged, exactly one done pulse, busy stays high through DONE.
- rst_n asserted in cycle 3 of RUN → busy, done, sum, c_out, ovf, rca_* at 0 immediately; new start after release (0x0001+0x0001) → sum=0x0002 after 5 cycles.
